// File: rtl/demux_pkg.sv
// Shared sizing constants and the select-to-lane helper for the demux_8x1 family.
package demux_pkg;

  localparam int N_OUT     = 8;
  localparam int SEL_W     = 3;
  localparam int SLICE_OUT = 4;
  localparam int N_SLICE   = N_OUT / SLICE_OUT;

  // s1 is the most significant select bit.
  function automatic logic [SEL_W-1:0] lane_idx(
    input logic s1,
    input logic s2,
    input logic s3
  );
    return {s1, s2, s3};
  endfunction

endpackage

// File: rtl/demux_1x4.sv
// Combinational 1-to-4 demux slice; all lanes are zero unless enabled.
module demux_1x4
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                          en,
  input  logic [DATA_W-1:0]             a,
  input  logic [1:0]                    sel,
  output logic [SLICE_OUT*DATA_W-1:0]   y
);

  genvar gi;
  generate
    for (gi = 0; gi < SLICE_OUT; gi++) begin : g_lane
      assign y[gi*DATA_W +: DATA_W] = (en && (sel == 2'(gi))) ? a : '0;
    end
  endgenerate

endmodule

// File: rtl/demux_8x1.sv
// 1-to-8 demux with registered outputs, built from two 1x4 slices chosen by s1.
// Optional simulation checker enabled by DEMUX_8X1_ONEHOT_CHECK_EN.
module demux_8x1
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         a,
  input  logic                      s1,
  input  logic                      s2,
  input  logic                      s3,
  output logic [N_OUT*DATA_W-1:0]   out
);

  localparam int SLICE_W = SLICE_OUT * DATA_W;

  logic [SEL_W-1:0]              sel;
  logic [SLICE_W-1:0]            slice_y [N_SLICE];
  logic [N_OUT*DATA_W-1:0]       out_d;
  logic [N_OUT*DATA_W-1:0]       out_q;

  assign sel = lane_idx(s1, s2, s3);

  // Slice 0 serves lanes 0-3 (s1 = 0), slice 1 serves lanes 4-7 (s1 = 1).
  genvar gi;
  generate
    for (gi = 0; gi < N_SLICE; gi++) begin : g_slice
      demux_1x4 #(
        .DATA_W (DATA_W)
      ) u_slice (
        .en  ((gi == 1) ? sel[SEL_W-1] : ~sel[SEL_W-1]),
        .a   (a),
        .sel (sel[1:0]),
        .y   (slice_y[gi])
      );
    end
  endgenerate

  always_comb begin
    out_d = '0;
    for (int i = 0; i < N_SLICE; i++) begin
      out_d[i*SLICE_W +: SLICE_W] = slice_y[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef DEMUX_8X1_ONEHOT_CHECK_EN
  logic [SEL_W-1:0]  chk_sel_q;
  logic [DATA_W-1:0] chk_a_q;
  logic              chk_live_q;

  always_ff @(posedge clk) begin
    chk_sel_q  <= sel;
    chk_a_q    <= a;
    chk_live_q <= rst_n;
  end

  // Checked half a cycle after the edge so out_q has settled.
  always @(negedge clk) begin
    if (chk_live_q) begin
      int nz;
      nz = 0;
      for (int i = 0; i < N_OUT; i++) begin
        if (out_q[i*DATA_W +: DATA_W] != '0) begin
          nz++;
          if (i != int'(chk_sel_q)) begin
            $error("demux_8x1 @%0t: lane %0d active, sel=%0d out=%h", $time, i, chk_sel_q, out_q);
          end
        end
      end
      if (nz > 1) begin
        $error("demux_8x1 @%0t: %0d lanes active, sel=%0d out=%h", $time, nz, chk_sel_q, out_q);
      end
      if (out_q[chk_sel_q*DATA_W +: DATA_W] != chk_a_q) begin
        $error("demux_8x1 @%0t: selected lane mismatch, sel=%0d out=%h", $time, chk_sel_q, out_q);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_demux_8x1.sv
// Directed self-checking bench for demux_8x1 at DATA_W = 1 and DATA_W = 4.
module tb_demux_8x1;

  logic        clk;
  logic        rst_n;
  logic        a;
  logic [3:0]  a4;
  logic        s1, s2, s3;
  logic [7:0]  out;
  logic [31:0] out4;

  int checks = 0;
  int errors = 0;

  demux_8x1 #(.DATA_W(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .s1    (s1),
    .s2    (s2),
    .s3    (s3),
    .out   (out)
  );

  demux_8x1 #(.DATA_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a4),
    .s1    (s1),
    .s2    (s2),
    .s3    (s3),
    .out   (out4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%h", tag, obs);
    end
  endtask

  task automatic set_sel(input logic [2:0] v);
    {s1, s2, s3} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 1'b1;
    a4    = 4'h0;
    set_sel(3'b101);

    // Reset held for two edges, then released.
    tick();
    check_val("rst_edge1", {24'h0, out}, 32'h00);
    check_val("rst_edge1_w4", out4, 32'h0);
    tick();
    check_val("rst_edge2", {24'h0, out}, 32'h00);
    rst_n = 1'b1;
    tick();
    check_val("rst_release", {24'h0, out}, 32'h20);

    // Full sweep with a = 1.
    a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_sel(3'(i));
      tick();
      check_val($sformatf("sweep_a1_sel%0d", i), {24'h0, out}, 32'h1 << i);
    end

    // Zero data sweep.
    a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_sel(3'(i));
      tick();
      check_val($sformatf("sweep_a0_sel%0d", i), {24'h0, out}, 32'h0);
    end

    // Back-to-back select changes.
    a = 1'b1;
    set_sel(3'b011);
    tick();
    check_val("b2b_sel3", {24'h0, out}, 32'h08);
    set_sel(3'b110);
    tick();
    check_val("b2b_sel6", {24'h0, out}, 32'h40);

    // Reset in mid-stream.
    set_sel(3'b111);
    tick();
    check_val("mid_before", {24'h0, out}, 32'h80);
    rst_n = 1'b0;
    tick();
    check_val("mid_reset", {24'h0, out}, 32'h00);
    rst_n = 1'b1;
    tick();
    check_val("mid_after", {24'h0, out}, 32'h80);

    // Wide lanes.
    a4 = 4'hA;
    set_sel(3'b010);
    tick();
    check_val("w4_sel2_A", out4, 32'h00000A00);
    a4 = 4'h5;
    set_sel(3'b111);
    tick();
    check_val("w4_sel7_5", out4, 32'h50000000);
    a4 = 4'h3;
    set_sel(3'b100);
    tick();
    check_val("w4_sel4_3", out4, 32'h00030000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_8x1.md
Name: demux_8x1

Overview:
- 1-to-8 demultiplexer with a registered output stage.
- Routes the single data input `a` to one of eight output lanes, selected by the 3-bit select {s1,s2,s3}. Unselected lanes are driven to zero.
- Built from two 1-to-4 demux slices; s1 chooses the slice.
- Used as a generic fan-out and steering primitive in the combinational and datapath library.

Parameters:
- DATA_W, 1, width of data input `a` and of each output lane.

Ports:
- clk    input   1           single clock; all state updates on the rising edge
- rst_n  input   1           synchronous, active-low reset
- a      input   DATA_W      data to be steered
- s1     input   1           select MSB (bit 2)
- s2     input   1           select bit 1
- s3     input   1           select LSB (bit 0)
- out    output  8*DATA_W    lane k is out[k*DATA_W +: DATA_W], k = {s1,s2,s3}

Behaviour:
- Select index: sel = {s1,s2,s3}, value 0..7; s1 is the MSB.
- Combinational next value:
  - lane[sel] = a
  - every other lane = 0
- Register stage:
  - On each rising clk edge with rst_n = 1, out <= next value.
  - Latency from a or select change to out is exactly 1 cycle.
- Reset:
  - On a rising edge with rst_n = 0, out <= 0 (all 8*DATA_W bits).
  - Reset is sampled only at the clock edge, and it wins over any input on that edge.
  - Reset asserted mid-stream clears out on that edge. The first post-reset edge with rst_n = 1 loads the current selection; no extra flush cycle.
- Output state:
  - out is always one-hot-or-zero at lane granularity.
  - With a = 0, all lanes are 0 regardless of select.
- Select changes every cycle: each cycle's out reflects only the select and `a` sampled at the previous edge. There is no hold or glitch between lanes.
- Slice structure:
  - Lower slice (lanes 0-3) is enabled when s1 = 0.
  - Upper slice (lanes 4-7) is enabled when s1 = 1.
  - Inside a slice, {s2,s3} picks lane 0..3.
  - A disabled slice outputs 0.
- No handshake. The block accepts a new input every cycle.

Optional Feature:
- Macro: DEMUX_8X1_ONEHOT_CHECK_EN
- Defined: simulation-only checks in the top level, both excluded from synthesis:
  - After every non-reset edge, out has at most one nonzero lane.
  - That lane equals the lane indexed by the previously sampled select.
  - A violation reports an error with time, select and out.
- Undefined: no checker code is compiled. Functional behaviour is identical.

Decomposition:
- Package demux_pkg:
  - N_OUT = 8
  - SEL_W = 3
  - SLICE_OUT = 4
  - a lane-index helper function mapping {s1,s2,s3} to 0..7
- Sub-module demux_1x4 (combinational):
  - Inputs: en, a[DATA_W], sel[1:0]. Output: y[4*DATA_W].
  - y lane sel = a when en = 1; all other lanes, and all lanes when en = 0, are 0.
  - Instantiated twice in demux_8x1. Enables are ~s1 and s1.
- The output register lives only in the top level.

Test Plan:
- Reset: rst_n = 0 for 2 edges with a = 1, sel = 3'b101 -> out = 8'b00000000 on both edges. Release: next edge gives out = 8'b00100000.
- Full sweep: a = 1, sel stepped 000..111, one per cycle -> out one cycle later = 00000001, 00000010, 00000100, ... 10000000. Confirms s1 is the MSB, e.g. sel 100 -> 00010000.
- Zero data: a = 0, sel swept 000..111 -> out = 8'b00000000 every cycle.
- Latency and back-to-back: sel 011 then 110 on consecutive edges, a = 1 -> out = 00001000, then 01000000, with no cycle where both bits are set.
- Reset mid-operation: sel = 111, a = 1 steady; pull rst_n low for 1 edge -> out goes 10000000, then 00000000, then 10000000.
- DATA_W = 4: a = 4'hA, sel = 010 -> out = 32'h00000A00.
